// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small transmit FIFO; frames are 8N1-style with
// optional parity (macro UART_TX_PARITY_EN) and one or two stop bits.
// Ports: sysclk clock; reset sync active-high; parity_i/stop2_i frame format
// (latched per frame); wr_en_i/wr_data_i FIFO write; full_o/empty_o/level_o
// FIFO status; ovf_o sticky dropped-write flag; busy_o FSM active;
// tx_end_o last cycle of a frame; tx_o registered serial line (idle high).
module uart_tx_fifo #(
    parameter int N     = 8,
    parameter int DIV   = 10,
    parameter int DEPTH = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [1:0]               parity_i,
    input  logic                     stop2_i,
    input  logic                     wr_en_i,
    input  logic [N-1:0]             wr_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic                     busy_o,
    output logic                     tx_end_o,
    output logic                     tx_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          push, pop;

    state_t        state_q, state_n;
    logic [CW-1:0] cyc_q, cyc_n;
    logic [3:0]    bit_q, bit_n;
    logic [N-1:0]  data_q, data_n;
    logic          stop2_q, stop2_n;
    logic          last_cyc;
    logic          tx_d;
`ifdef UART_TX_PARITY_EN
    logic          par_en_q, par_en_n;
    logic          par_bit_q, par_bit_n;
`else
    logic          unused_parity;
    assign unused_parity = ^parity_i;
`endif

    assign full_o   = (count == LW'(DEPTH));
    assign empty_o  = (count == '0);
    assign level_o  = count;
    assign busy_o   = (state_q != IDLE);
    assign push     = wr_en_i && !full_o;
    assign last_cyc = (cyc_q == CW'(DIV - 1));

    always_ff @(posedge sysclk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A write against a full FIFO is lost even if a pop frees a slot
            if (wr_en_i && full_o) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            stop2_q   <= 1'b0;
            tx_o      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cyc_q     <= cyc_n;
            bit_q     <= bit_n;
            data_q    <= data_n;
            stop2_q   <= stop2_n;
            tx_o      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        cyc_n     = cyc_q;
        bit_n     = bit_q;
        data_n    = data_q;
        stop2_n   = stop2_q;
        pop       = 1'b0;
        tx_end_o  = 1'b0;
        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_en_n  = par_en_q;
        par_bit_n = par_bit_q;
`endif
        if (state_q != IDLE) begin
            cyc_n = last_cyc ? '0 : cyc_q + 1'b1;
        end

        case (state_q)
            START: begin
                if (last_cyc) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    if (bit_q == 4'(N - 1)) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = par_en_q ? PARITY : STOP;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n  = bit_q + 1'b1;
                        data_n = data_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_cyc) begin
                    state_n = STOP;
                    bit_n   = '0;
                end
            end
`endif
            STOP: begin
                if (last_cyc) begin
                    if (bit_q == {3'b000, stop2_q}) begin
                        tx_end_o = 1'b1;
                        state_n  = IDLE;
                        bit_n    = '0;
                    end else begin
                        bit_n = bit_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Reload straight from the last stop cycle so frames run back-to-back
        if ((state_q == IDLE || tx_end_o) && !empty_o) begin
            pop     = 1'b1;
            state_n = START;
            cyc_n   = '0;
            bit_n   = '0;
            data_n  = mem[rd_ptr];
            stop2_n = stop2_i;
`ifdef UART_TX_PARITY_EN
            par_en_n  = (parity_i == 2'b01) || (parity_i == 2'b10);
            par_bit_n = (^mem[rd_ptr]) ^ (parity_i == 2'b10);
`endif
        end

        // tx_o is registered, so it is driven from the state being entered
        case (state_n)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_n;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (N=8, DIV=10, DEPTH=4).
// Checks every cycle of each frame against a hand-built bit sequence.
module tb_uart_tx_fifo;

    localparam int N     = 8;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [1:0] parity_i;
    logic       stop2_i;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       full_o, empty_o, ovf_o, busy_o, tx_end_o, tx_o;
    logic [2:0] level_o;

    int checks = 0;
    int passed = 0;
    logic [7:0] pend [8];

    uart_tx_fifo #(.N(N), .DIV(DIV), .DEPTH(DEPTH)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .parity_i  (parity_i),
        .stop2_i   (stop2_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .level_o   (level_o),
        .ovf_o     (ovf_o),
        .busy_o    (busy_o),
        .tx_end_o  (tx_end_o),
        .tx_o      (tx_o)
    );

    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Caller sits just after the edge before the frame's first cycle.
    // pend[0..np-1] are written on the first np edges of the frame.
    // flip changes the format inputs mid-frame; the frame must not change.
    task automatic run_frame(input logic [7:0] d, input bit pe,
                             input bit pb, input int stops, input int np,
                             input bit flip, input string tag);
        int len;
        int idx;
        logic e;
        len = (1 + N + (pe ? 1 : 0) + stops) * DIV;
        for (int c = 1; c <= len; c++) begin
            if (c - 1 < np) begin
                wr_en_i   = 1'b1;
                wr_data_i = pend[c-1];
            end else begin
                wr_en_i = 1'b0;
            end
            if (flip && c == 20) begin
                stop2_i  = ~stop2_i;
                parity_i = 2'b01;
            end
            step();
            idx = (c - 1) / DIV;
            if (idx == 0) e = 1'b0;
            else if (idx <= N) e = d[idx-1];
            else if (pe && idx == N + 1) e = pb;
            else e = 1'b1;
            chk({tag, "_tx"}, {8'h0, tx_o}, {8'h0, e});
            chk({tag, "_end"}, {8'h0, tx_end_o}, {8'h0, c == len});
            chk({tag, "_busy"}, {8'h0, busy_o}, 9'h1);
        end
        wr_en_i = 1'b0;
    endtask

    initial begin
        int lows;
        reset     = 1'b1;
        parity_i  = 2'b00;
        stop2_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = 8'h00;
        step();
        step();
        reset = 1'b0;
        chk("rst_tx", {8'h0, tx_o}, 9'h1);
        chk("rst_busy", {8'h0, busy_o}, 9'h0);
        chk("rst_empty", {8'h0, empty_o}, 9'h1);
        chk("rst_full", {8'h0, full_o}, 9'h0);
        chk("rst_level", {6'h0, level_o}, 9'h0);
        chk("rst_ovf", {8'h0, ovf_o}, 9'h0);
        chk("rst_end", {8'h0, tx_end_o}, 9'h0);

        // 0x55, no parity, one stop bit; format inputs change mid-frame
        wr_en_i   = 1'b1;
        wr_data_i = 8'h55;
        step();
        chk("w55_level", {6'h0, level_o}, 9'h1);
        chk("w55_tx_idle", {8'h0, tx_o}, 9'h1);
        run_frame(8'h55, 1'b0, 1'b0, 1, 0, 1'b1, "f55");
        stop2_i  = 1'b0;
        parity_i = 2'b00;
        step();
        chk("f55_idle_busy", {8'h0, busy_o}, 9'h0);
        chk("f55_idle_tx", {8'h0, tx_o}, 9'h1);

`ifdef UART_TX_PARITY_EN
        parity_i  = 2'b01;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h55;
        step();
        run_frame(8'h55, 1'b1, 1'b0, 1, 0, 1'b0, "even");
        step();
        parity_i  = 2'b10;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h55;
        step();
        run_frame(8'h55, 1'b1, 1'b1, 1, 0, 1'b0, "odd");
        step();
        parity_i = 2'b00;
`endif

        // Two back-to-back frames with two stop bits
        stop2_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_data_i = 8'hA5;
        pend[0]   = 8'h3C;
        step();
        run_frame(8'hA5, 1'b0, 1'b0, 2, 1, 1'b0, "fA5");
        run_frame(8'h3C, 1'b0, 1'b0, 2, 0, 1'b0, "f3C");
        step();
        chk("b2b_idle", {8'h0, busy_o}, 9'h0);
        stop2_i = 1'b0;

        // Overflow: six writes, the sixth is dropped
        wr_en_i   = 1'b1;
        wr_data_i = 8'h01;
        pend[0] = 8'h02;
        pend[1] = 8'h03;
        pend[2] = 8'h04;
        pend[3] = 8'h05;
        pend[4] = 8'h06;
        step();
        run_frame(8'h01, 1'b0, 1'b0, 1, 5, 1'b0, "o01");
        chk("ovf_flag", {8'h0, ovf_o}, 9'h1);
        chk("ovf_full", {8'h0, full_o}, 9'h1);
        chk("ovf_level", {6'h0, level_o}, 9'h4);
        run_frame(8'h02, 1'b0, 1'b0, 1, 0, 1'b0, "o02");
        run_frame(8'h03, 1'b0, 1'b0, 1, 0, 1'b0, "o03");
        run_frame(8'h04, 1'b0, 1'b0, 1, 0, 1'b0, "o04");
        run_frame(8'h05, 1'b0, 1'b0, 1, 0, 1'b0, "o05");
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
        end
        chk("ovf_no06", lows[8:0], 9'h0);
        chk("ovf_empty", {8'h0, empty_o}, 9'h1);
        chk("ovf_sticky", {8'h0, ovf_o}, 9'h1);

        // Reset during DATA with two entries queued
        wr_en_i   = 1'b1;
        wr_data_i = 8'h11;
        step();
        wr_data_i = 8'h22;
        step();
        wr_data_i = 8'h33;
        step();
        wr_en_i = 1'b0;
        chk("mr_level", {6'h0, level_o}, 9'h2);
        for (int c = 0; c < 20; c++) step();
        chk("mr_busy_pre", {8'h0, busy_o}, 9'h1);
        reset     = 1'b1;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h77;
        step();
        reset   = 1'b0;
        wr_en_i = 1'b0;
        chk("mr_tx", {8'h0, tx_o}, 9'h1);
        chk("mr_level0", {6'h0, level_o}, 9'h0);
        chk("mr_busy", {8'h0, busy_o}, 9'h0);
        chk("mr_ovf", {8'h0, ovf_o}, 9'h0);
        chk("mr_empty", {8'h0, empty_o}, 9'h1);
        chk("mr_full", {8'h0, full_o}, 9'h0);
        lows = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
        end
        chk("mr_silent", lows[8:0], 9'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter N, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter DIV, default 10, sysclk cycles per bit time; legal range 2 or more.
REQ-003 SHALL have parameter DEPTH, default 4, transmit FIFO entries; power of 2, legal range 2..64.
REQ-004 SHALL have port: sysclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: parity_i  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-007 SHALL have port: stop2_i  in  1  1 selects two stop bits, 0 selects one.
REQ-008 SHALL have port: wr_en_i  in  1  FIFO write request.
REQ-009 SHALL have port: wr_data_i  in  N  FIFO write data.
REQ-010 SHALL have port: full_o  out  1  FIFO holds DEPTH entries.
REQ-011 SHALL have port: empty_o  out  1  FIFO holds 0 entries.
REQ-012 SHALL have port: level_o  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port: ovf_o  out  1  sticky flag, set by a rejected write.
REQ-014 SHALL have port: busy_o  out  1  FSM not in IDLE.
REQ-015 SHALL have port: tx_end_o  out  1  one-cycle pulse at frame end.
REQ-016 SHALL have port: tx_o  out  1  registered serial line; idle high.

Function
REQ-017 SHALL accept a write on a rising edge when wr_en_i=1 and full_o=0; a write with full_o=1 SHALL be dropped and SHALL set ovf_o, even if a pop occurs on the same edge.
REQ-018 SHALL support a simultaneous push and pop when not full; level_o is then unchanged.
REQ-019 SHALL implement the FIFO as a first-in first-out buffer whose pointers wrap modulo DEPTH.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP; each bit occupies exactly DIV cycles of tx_o.
REQ-021 SHALL, on any edge where the FSM is in IDLE or in the last cycle of STOP and empty_o=0, pop the head entry, latch the data together with parity_i and stop2_i, and enter START.
REQ-022 SHALL drive tx_o low in START for one bit time.
REQ-023 SHALL drive N data bits LSB first in DATA.
REQ-024 SHALL enter PARITY only when the latched mode is even or odd.
- Even parity: bit = XOR of the data bits.
- Odd parity: bit = inverse of that XOR.
REQ-025 SHALL drive tx_o high in STOP for 1 or 2 bit times, as latched.
REQ-026 SHALL pulse tx_end_o on the last cycle of STOP.
REQ-027 SHALL return the FSM to IDLE with tx_o=1 when the FIFO is empty at the end of STOP.
REQ-028 SHALL transmit back-to-back frames with no idle cycle between them.
REQ-029 SHALL produce a frame length of (1+N+P+S)*DIV cycles, where P is 0 or 1 and S is 1 or 2.
REQ-030 SHALL meet this latency: write accepted at edge k into an idle, empty block -> tx_o low from edge k+1.
REQ-031 SHALL ignore changes on parity_i and stop2_i mid-frame; they take effect from the next frame.

Reset
REQ-032 SHALL, with reset=1 at a rising edge, force the following values on the next cycle, discarding both the FIFO contents and any frame in progress:
- FSM: IDLE; bit and cycle counters 0.
- tx_o=1, busy_o=0, tx_end_o=0, ovf_o=0.
- full_o=0, empty_o=1, level_o=0.
REQ-033 SHALL ignore wr_en_i while reset=1.

Configuration
REQ-034 SHALL honour parity_i as specified when macro UART_TX_PARITY_EN is defined.
REQ-035 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and parity logic; parity_i remains a port, is ignored, and P=0 always.

Verification
REQ-036 SHALL cover: N=8, DIV=10, parity none, 1 stop, write 0x55 -> tx_o low 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then high 10 cycles; tx_end_o pulses at cycle 100 of the frame.
REQ-037 SHALL cover, with macro defined: write 0x55 with even parity -> parity bit 0; with odd parity -> parity bit 1; frame length 110 cycles.
REQ-038 SHALL cover: 0xA5 and 0x3C written on consecutive cycles, stop2_i=1 -> two contiguous 110-cycle frames with no idle gap; two tx_end_o pulses, 110 cycles apart.
REQ-039 SHALL cover: DEPTH=4, six consecutive writes 0x01..0x06 into an idle block -> 0x06 dropped, ovf_o=1, full_o=1; frames 0x01..0x05 sent in order.
REQ-040 SHALL cover: reset asserted during DATA of a frame with 2 entries queued -> next cycle tx_o=1, level_o=0, busy_o=0, ovf_o=0; no further frames sent.
